lcd_ctrl: RTL
=============

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter T_SU, default 2: cycles of RS/DATA setup before EN rises.
REQ-002 SHALL have parameter T_EN, default 12: cycles EN is held high.
REQ-003 SHALL have parameter T_HOLD, default 2: cycles RS/DATA are held after EN falls.
REQ-004 SHALL have parameter T_CMD, default 2000: busy wait after an ordinary write.
REQ-005 SHALL have parameter T_CLR, default 82000: busy wait after a clear (0x01) or home (0x02) command.
REQ-006 SHALL have parameter T_PWR, default 750000: power-up wait before initialisation.
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-008 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port wr_valid_i, input, 1 bit: a write request is offered.
REQ-010 SHALL have port wr_ready_o, output, 1 bit: the request is accepted this cycle.
REQ-011 SHALL have port wr_rs_i, input, 1 bit: 0 = command, 1 = character data.
REQ-012 SHALL have port wr_data_i, input, 8 bits: byte to write.
REQ-013 SHALL have ports lcd_data_o (8 bits) and lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o (1 bit each), all outputs: HD44780 panel pins.
REQ-014 SHALL have port busy_o, output, 1 bit: init in progress, or a transfer or busy wait is active.
REQ-015 SHALL have port init_done_o, output, 1 bit: power-up sequence complete.

Function
REQ-016 SHALL transfer a request only in a cycle where wr_valid_i and wr_ready_o are both high.
REQ-017 SHALL use FSM states PWRUP, INIT_LOAD, IDLE, SETUP, EN_HI, HOLD, WAIT.
REQ-018 SHALL go PWRUP -> INIT_LOAD after T_PWR cycles.
REQ-019 SHALL have INIT_LOAD issue the fixed commands 0x38, 0x0C, 0x01, 0x06 in order, each as a command write through SETUP/EN_HI/HOLD/WAIT.
REQ-020 SHALL set init_done_o and enter IDLE after the WAIT of the fourth init command.
REQ-021 SHALL, in IDLE with a pending byte, latch RS/DATA onto the pins and go to SETUP.
REQ-022 SHALL advance SETUP (T_SU cycles) -> EN_HI (T_EN cycles, lcd_en_o = 1) -> HOLD (T_HOLD cycles) -> WAIT.
REQ-023 SHALL stay in WAIT for T_CLR cycles when RS = 0 and the data is 0x01 or 0x02, and T_CMD cycles otherwise, then return to IDLE.
REQ-024 SHALL keep lcd_data_o and lcd_rs_o constant from SETUP entry through HOLD exit.
REQ-025 SHALL hold lcd_en_o high only in EN_HI.
REQ-026 SHALL tie lcd_rw_o to 0 (write-only).
REQ-027 SHALL drive lcd_on_o = 1 from the first cycle after reset release.
REQ-028 SHALL use one down-counter sized $clog2 of the largest timing parameter + 1; it loads N-1 on state entry and the state exits when the counter reaches 0.
REQ-029 SHALL treat a timing parameter of 0 as 1.
REQ-030 SHALL drive busy_o = 1 in every state except IDLE with no pending byte.
REQ-031 SHALL keep all outputs registered, with no combinational path from inputs to panel pins.

Reset
REQ-032 SHALL, on rst_ni low, immediately reach state PWRUP with all outputs 0 (wr_ready_o, busy_o, init_done_o, lcd_*) and the counter loaded with T_PWR-1.
REQ-033 SHALL, on rst_ni low mid-transfer, drop lcd_en_o in the same cycle, discard the byte and any queued bytes, and rerun the full init sequence after release.
REQ-034 SHALL release reset asynchronously-asserted, synchronously-deasserted, with the synchroniser outside this block.

Configuration
REQ-035 SHALL support macro LCD_CTRL_FIFO_EN.
REQ-036 SHALL, when LCD_CTRL_FIFO_EN is defined, buffer requests in a 4-entry FIFO of {rs, data}: wr_ready_o = FIFO not full (accepting during PWRUP/init), simultaneous push and pop allowed when full, and the FIFO drained in IDLE.
REQ-037 SHALL, when LCD_CTRL_FIFO_EN is undefined, use a single holding register: wr_ready_o = 1 only in IDLE with init_done_o = 1 and no pending byte.

Structure
REQ-038 SHALL place the FSM state enum, the init command array (0x38, 0x0C, 0x01, 0x06), the clear/home opcodes and the timing defaults in package lcd_pkg.
REQ-039 SHALL implement the buffer as sub-module lcd_fifo (parameter DEPTH, full/empty flags, pointers wrapping modulo DEPTH).

Verification
REQ-040 SHALL check power-up, with T_PWR=10, T_CMD=5, T_CLR=20: release reset -> 4 EN pulses carrying 0x38, 0x0C, 0x01, 0x06 with RS = 0, a 20-cycle wait after 0x01, then init_done_o = 1.
REQ-041 SHALL check a character write: write rs=1, data=0x41 -> lcd_data_o = 0x41 and lcd_rs_o = 1 stable across an EN pulse of exactly T_EN cycles, busy_o low after T_CMD.
REQ-042 SHALL check the clear wait: write rs=0, data=0x01 -> next EN rise no earlier than T_CLR cycles after HOLD exit.
REQ-043 SHALL check back-pressure with the FIFO enabled: 5 back-to-back writes during init -> wr_ready_o low on the 5th, and 0x30..0x33 emitted in order after init.
REQ-044 SHALL check reset mid-transfer: assert rst_ni during EN_HI -> lcd_en_o = 0 the same cycle, the init sequence repeats, and no stale byte is emitted.
REQ-045 SHALL check operation without the FIFO: wr_valid_i held during WAIT -> wr_ready_o = 0 until IDLE, then a single-cycle acceptance.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write controller: FSM states,
// power-up command list, slow-opcode detection and timing defaults.
package lcd_pkg;

   typedef enum logic [2:0] {
      PWRUP     = 3'd0,
      INIT_LOAD = 3'd1,
      IDLE      = 3'd2,
      SETUP     = 3'd3,
      EN_HI     = 3'd4,
      HOLD      = 3'd5,
      WAIT      = 3'd6
   } lcd_state_e;

   localparam int unsigned N_INIT = 4;
   localparam logic [7:0] INIT_CMDS [N_INIT] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;

   localparam int unsigned T_SU_DEF   = 2;
   localparam int unsigned T_EN_DEF   = 12;
   localparam int unsigned T_HOLD_DEF = 2;
   localparam int unsigned T_CMD_DEF  = 2000;
   localparam int unsigned T_CLR_DEF  = 82000;
   localparam int unsigned T_PWR_DEF  = 750000;

   localparam int unsigned FIFO_DEPTH = 4;

   // A zero-length phase would never let the counter reach its exit value.
   function automatic int unsigned tcyc(input int unsigned n);
      return (n == 0) ? 1 : n;
   endfunction

   function automatic int unsigned tmax(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic is_slow(input logic rs, input logic [7:0] d);
      return !rs && ((d == CMD_CLEAR) || (d == CMD_HOME));
   endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Write-request handshake between a byte producer and the LCD controller.
interface lcd_ctrl_if;
   logic       valid;
   logic       ready;
   logic       rs;
   logic [7:0] data;

   modport master (output valid, output rs, output data, input ready);
   modport slave  (input valid, input rs, input data, output ready);
endinterface

// File: rtl/lcd_fifo.sv
// Request buffer of {rs, data} used when LCD_CTRL_FIFO_EN is defined;
// ready is registered and reflects "not full" for the following cycle.
module lcd_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   lcd_ctrl_if.slave        wr,
   input  logic             pop_i,
   output logic             empty_o,
   output logic             empty_nxt_o,
   output logic             rd_rs_o,
   output logic [7:0]       rd_data_o
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = $clog2(DEPTH + 1);

   logic [8:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level_q, level_d;
   logic          full, push, pop, ready_q;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full        = (level_q == LW'(DEPTH));
   assign empty_o     = (level_q == '0);
   assign pop         = pop_i & ~empty_o;
   assign push        = wr.valid & ready_q & (~full | pop);
   assign empty_nxt_o = (level_d == '0);
   assign wr.ready    = ready_q;
   assign {rd_rs_o, rd_data_o} = mem[rd_ptr];

   always_comb begin
      level_d = level_q;
      if (push && !pop)
         level_d = level_q + 1'b1;
      else if (pop && !push)
         level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (push)
         mem[wr_ptr] <= {wr.rs, wr.data};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         ready_q <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= inc(wr_ptr);
         if (pop)
            rd_ptr <= inc(rd_ptr);
         level_q <= level_d;
         ready_q <= (level_d != LW'(DEPTH));
      end
   end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit write-only controller with power-up init sequence.
// Optional request FIFO enabled by defining LCD_CTRL_FIFO_EN.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned T_SU   = T_SU_DEF,
   parameter int unsigned T_EN   = T_EN_DEF,
   parameter int unsigned T_HOLD = T_HOLD_DEF,
   parameter int unsigned T_CMD  = T_CMD_DEF,
   parameter int unsigned T_CLR  = T_CLR_DEF,
   parameter int unsigned T_PWR  = T_PWR_DEF
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       wr_valid_i,
   output logic       wr_ready_o,
   input  logic       wr_rs_i,
   input  logic [7:0] wr_data_i,
   output logic [7:0] lcd_data_o,
   output logic       lcd_rs_o,
   output logic       lcd_rw_o,
   output logic       lcd_en_o,
   output logic       lcd_on_o,
   output logic       busy_o,
   output logic       init_done_o
);
   localparam int unsigned T_MAX = tmax(tmax(tmax(tcyc(T_SU), tcyc(T_EN)),
                                             tmax(tcyc(T_HOLD), tcyc(T_CMD))),
                                        tmax(tcyc(T_CLR), tcyc(T_PWR)));
   localparam int unsigned CW = $clog2(T_MAX + 1);
   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t LD_SU   = cnt_t'(tcyc(T_SU) - 1);
   localparam cnt_t LD_EN   = cnt_t'(tcyc(T_EN) - 1);
   localparam cnt_t LD_HOLD = cnt_t'(tcyc(T_HOLD) - 1);
   localparam cnt_t LD_CMD  = cnt_t'(tcyc(T_CMD) - 1);
   localparam cnt_t LD_CLR  = cnt_t'(tcyc(T_CLR) - 1);
   localparam cnt_t LD_PWR  = cnt_t'(tcyc(T_PWR) - 1);

   lcd_state_e state_q, state_d;
   cnt_t       cnt_q, cnt_d;
   logic [1:0] idx_q, idx_d;
   logic       done_q, done_d;
   logic [7:0] data_q, data_d;
   logic       rs_q, rs_d;
   logic       en_q, busy_q, on_q;
   logic       take;
   logic       pend, pend_rs, pend_d;
   logic [7:0] pend_data;

   lcd_ctrl_if wr_if ();

   assign wr_if.valid = wr_valid_i;
   assign wr_if.rs    = wr_rs_i;
   assign wr_if.data  = wr_data_i;
   assign wr_ready_o  = wr_if.ready;

`ifdef LCD_CTRL_FIFO_EN
   logic fifo_empty, fifo_empty_nxt;

   lcd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .wr          (wr_if),
      .pop_i       (take),
      .empty_o     (fifo_empty),
      .empty_nxt_o (fifo_empty_nxt),
      .rd_rs_o     (pend_rs),
      .rd_data_o   (pend_data)
   );

   assign pend   = ~fifo_empty;
   assign pend_d = ~fifo_empty_nxt;
`else
   logic       hold_q, hold_rs_q, ready_q, accept;
   logic [7:0] hold_data_q;

   assign accept      = wr_if.valid & ready_q;
   assign wr_if.ready = ready_q;
   assign pend        = hold_q;
   assign pend_rs     = hold_rs_q;
   assign pend_data   = hold_data_q;
   assign pend_d      = accept | (hold_q & ~take);

   // Ready is precomputed from next-state so the handshake pin stays registered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_q      <= 1'b0;
         hold_rs_q   <= 1'b0;
         hold_data_q <= '0;
         ready_q     <= 1'b0;
      end else begin
         if (accept) begin
            hold_q      <= 1'b1;
            hold_rs_q   <= wr_if.rs;
            hold_data_q <= wr_if.data;
         end else if (take) begin
            hold_q <= 1'b0;
         end
         ready_q <= (state_d == IDLE) & done_d & ~pend_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      idx_d   = idx_q;
      done_d  = done_q;
      data_d  = data_q;
      rs_d    = rs_q;
      take    = 1'b0;
      unique case (state_q)
         PWRUP:
            if (cnt_q == '0) state_d = INIT_LOAD;
         INIT_LOAD: begin
            state_d = SETUP;
            cnt_d   = LD_SU;
            rs_d    = 1'b0;
            data_d  = INIT_CMDS[idx_q];
         end
         IDLE:
            if (pend) begin
               state_d = SETUP;
               cnt_d   = LD_SU;
               rs_d    = pend_rs;
               data_d  = pend_data;
               take    = 1'b1;
            end
         SETUP:
            if (cnt_q == '0) begin
               state_d = EN_HI;
               cnt_d   = LD_EN;
            end
         EN_HI:
            if (cnt_q == '0) begin
               state_d = HOLD;
               cnt_d   = LD_HOLD;
            end
         HOLD:
            if (cnt_q == '0) begin
               state_d = WAIT;
               cnt_d   = is_slow(rs_q, data_q) ? LD_CLR : LD_CMD;
            end
         WAIT:
            if (cnt_q == '0) begin
               if (done_q) begin
                  state_d = IDLE;
               end else if (idx_q == 2'(N_INIT - 1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = INIT_LOAD;
               end
            end
         default: state_d = PWRUP;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= PWRUP;
         cnt_q   <= LD_PWR;
         idx_q   <= '0;
         done_q  <= 1'b0;
         data_q  <= '0;
         rs_q    <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         on_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         data_q  <= data_d;
         rs_q    <= rs_d;
         en_q    <= (state_d == EN_HI);
         busy_q  <= ~((state_d == IDLE) & ~pend_d);
         on_q    <= 1'b1;
      end
   end

   assign lcd_data_o  = data_q;
   assign lcd_rs_o    = rs_q;
   assign lcd_rw_o    = 1'b0;
   assign lcd_en_o    = en_q;
   assign lcd_on_o    = on_q;
   assign busy_o      = busy_q;
   assign init_done_o = done_q;

endmodule
